sram_queue_ctrl: RTL
====================

Name: sram_queue_ctrl

Overview:
- FIFO controller that drives an external 1R1W synchronous SRAM macro through its ports (W0_*, R0_*; 1-cycle registered read latency).
- Presents that SRAM as a ready/valid queue: enq side in, deq side out.
- A 2-entry output buffer absorbs read latency and sustains 1 deq/cycle.
- A bypass path gives a short enq-to-deq latency when the queue is nearly empty.

Parameters:
- WIDTH, 32, data word width; equals SRAM data width.
- ADDR_W, 10, SRAM address width.
- DEPTH, 1024, SRAM entries; must equal 2^ADDR_W.

Ports:
- clock  in  1  single clock; also drives SRAM W0_clk/R0_clk.
- reset  in  1  synchronous, active-high.
- enq_valid  in  1  producer has a word.
- enq_ready  out  1  queue accepts a word this cycle.
- enq_bits  in  WIDTH  word to enqueue.
- deq_valid  out  1  head word available.
- deq_ready  in  1  consumer takes the head this cycle.
- deq_bits  out  WIDTH  head word.
- count  out  ADDR_W+2  total words held (SRAM + in-flight + buffer).
- W0_en  out  1  SRAM write enable.
- W0_addr  out  ADDR_W  SRAM write address.
- W0_data  out  WIDTH  SRAM write data.
- W0_mask  out  WIDTH/8  byte mask; tied all-ones.
- R0_en  out  1  SRAM read enable.
- R0_addr  out  ADDR_W  SRAM read address.
- R0_data  in  WIDTH  SRAM read data, valid only in the cycle after R0_en.

Behaviour:
- Clocking: one clock, `clock`. Reset is synchronous and active-high, on port `reset`.
- State:
  - wr_ptr, rd_ptr: ADDR_W bits each; wrap DEPTH-1 -> 0 naturally.
  - sram_cnt: 0..DEPTH.
  - inflight: 1 bit.
  - obuf[0:1] with ob_cnt 0..2, kept as an in-order pair; obuf[0] is the head.
- Reset:
  - All state is 0.
  - enq_ready=0 and deq_valid=0 while reset is asserted.
  - W0_en=0, R0_en=0, count=0.
  - A reset mid-operation discards all contents; SRAM contents are ignored afterwards.
- enq_fire = enq_valid & enq_ready. deq_fire = deq_valid & deq_ready.
- enq_ready = !reset & (sram_cnt != DEPTH).
  - Total capacity is DEPTH+2.
  - enq_ready does not depend on deq_ready.
- deq_valid = (ob_cnt != 0).
- deq_bits = obuf[0], registered; no combinational path from enq_bits.
- Bypass:
  - Condition: enq_fire & sram_cnt==0 & !inflight & (ob_cnt - deq_fire) < 2.
  - When taken, enq_bits is written into the next free obuf slot at the clock edge.
  - deq_valid is therefore high 1 cycle after enq_fire.
- Otherwise an enq_fire writes SRAM:
  - W0_en=1, W0_addr=wr_ptr, W0_data=enq_bits.
  - wr_ptr+=1 and sram_cnt+=1.
- Read issue:
  - Condition: issue = sram_cnt!=0 & (ob_cnt + inflight <= 1 | (ob_cnt + inflight == 2 & deq_fire)).
  - On issue: R0_en=1, R0_addr=rd_ptr, rd_ptr+=1, sram_cnt-=1, inflight<=1.
  - R0_en is never asserted otherwise.
- Capture:
  - When inflight=1, R0_data is appended to obuf at that edge; inflight clears unless a new read issues in the same cycle.
  - R0_data is never sampled in any other cycle.
- Same-cycle enq write and read issue: permitted.
  - The read uses rd_ptr, which always points at a previously committed entry.
  - SRAM latency (minimum non-bypass path) is therefore write at t, issue at t+1, capture at t+2, deq_valid at t+3.
- Ordering and pipeline rules:
  - Words leave in exact enqueue order.
  - Bypass never overtakes SRAM or in-flight words, because bypass requires sram_cnt==0 and !inflight.
  - Simultaneous deq_fire and capture/bypass: the buffer shifts and appends in the same cycle, so ob_cnt stays constant.
  - Invariant: ob_cnt + inflight <= 2 always. Any violation is a design error; assert it in the bench.
- count = sram_cnt + inflight + ob_cnt, registered-state derived.
- Throughput: with the SRAM non-empty and deq_ready held high, deq_fire occurs every cycle in steady state.

Test Plan:
- Reset, then enq 0xA5A5_0001 with deq_ready=0 -> no W0_en; deq_valid=1 next cycle, deq_bits=0xA5A5_0001, count=1.
- deq_ready=0, enq 1026 words 0..1025 -> the first 2 bypass into the buffer; W0_en for 1024 words at addresses 0..1023; enq_ready=0 after word 1025; count=1026.
- Continue from full, deq_ready=1 -> 1026 words out in order 0..1025; after the first read, one deq per cycle; count=0 at end; R0_addr runs 0..1023.
- Continuous enq and deq with random valid/ready for 5000 words -> order preserved; wr_ptr/rd_ptr wrap past 1023; invariant ob_cnt+inflight<=2 holds; scoreboard matches.
- SRAM path latency: fill the buffer (2 words), enq 0x1234 at cycle t, then deq continuously -> W0_en at t, R0_en at t+1 (once room exists), word delivered in order.
- Assert reset for 1 cycle with 500 words queued and a read in flight -> next cycle count=0, deq_valid=0; enq 0xBEEF then bypasses, deq_bits=0xBEEF one cycle later.

Source files
------------

// File: rtl/sram_queue_ctrl_if.sv
// Bundle of the queue-side handshake and the external 1R1W SRAM port signals.
// master is the controller's view; slave is the producer/consumer/SRAM side.
interface sram_queue_ctrl_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
);
  logic                  enq_valid;
  logic                  enq_ready;
  logic [WIDTH-1:0]      enq_bits;

  logic                  deq_valid;
  logic                  deq_ready;
  logic [WIDTH-1:0]      deq_bits;

  logic [ADDR_W+1:0]     count;

  logic                  W0_en;
  logic [ADDR_W-1:0]     W0_addr;
  logic [WIDTH-1:0]      W0_data;
  logic [WIDTH/8-1:0]    W0_mask;

  logic                  R0_en;
  logic [ADDR_W-1:0]     R0_addr;
  logic [WIDTH-1:0]      R0_data;

  modport master (
    input  enq_valid, enq_bits, deq_ready, R0_data,
    output enq_ready, deq_valid, deq_bits, count,
           W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr
  );

  modport slave (
    output enq_valid, enq_bits, deq_ready, R0_data,
    input  enq_ready, deq_valid, deq_bits, count,
           W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr
  );
endinterface

// File: rtl/sram_queue_ctrl.sv
// Ready/valid FIFO built on an external 1R1W SRAM with 1-cycle read latency.
// A 2-entry output buffer hides the read latency; near-empty words bypass the SRAM.
module sram_queue_ctrl #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic             clock,
  input  logic             reset,
  sram_queue_ctrl_if.master bus
);
  localparam int CNT_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  sram_cnt_q, sram_cnt_d;
  logic              inflight_q, inflight_d;
  logic [WIDTH-1:0]  obuf_q [2];
  logic [WIDTH-1:0]  obuf_d [2];
  logic [1:0]        ob_cnt_q, ob_cnt_d;

  logic              enq_ready_w;
  logic              deq_valid_w;
  logic              enq_fire;
  logic              deq_fire;
  logic [1:0]        ob_after_deq;
  logic [2:0]        occ;
  logic              bypass;
  logic              sram_wr;
  logic              issue;
  logic [WIDTH-1:0]  append_data;

  assign enq_ready_w  = !reset && (sram_cnt_q != CNT_W'(DEPTH));
  assign deq_valid_w  = !reset && (ob_cnt_q != 2'd0);
  assign enq_fire     = bus.enq_valid && enq_ready_w;
  assign deq_fire     = deq_valid_w && bus.deq_ready;

  assign ob_after_deq = ob_cnt_q - {1'b0, deq_fire};
  assign occ          = {1'b0, ob_cnt_q} + {2'b0, inflight_q};

  // Bypass only when nothing older sits in the SRAM or the read pipeline.
  assign bypass  = enq_fire && (sram_cnt_q == '0) && !inflight_q && (ob_after_deq < 2'd2);
  assign sram_wr = enq_fire && !bypass;

  // Keep buffered + in-flight words at most 2 so every capture has a slot.
  assign issue = !reset && (sram_cnt_q != '0) &&
                 ((occ <= 3'd1) || ((occ == 3'd2) && deq_fire));

  assign append_data = inflight_q ? bus.R0_data : bus.enq_bits;

  always_comb begin
    obuf_d   = obuf_q;
    ob_cnt_d = ob_after_deq;
    if (deq_fire) begin
      obuf_d[0] = obuf_q[1];
    end
    // Capture and bypass are mutually exclusive: bypass needs !inflight.
    if (inflight_q || bypass) begin
      if (ob_after_deq == 2'd0) begin
        obuf_d[0] = append_data;
      end else begin
        obuf_d[1] = append_data;
      end
      ob_cnt_d = ob_after_deq + 2'd1;
    end
  end

  assign wr_ptr_d   = wr_ptr_q + ADDR_W'(sram_wr);
  assign rd_ptr_d   = rd_ptr_q + ADDR_W'(issue);
  assign sram_cnt_d = sram_cnt_q + CNT_W'(sram_wr) - CNT_W'(issue);
  assign inflight_d = issue;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      inflight_q <= 1'b0;
      obuf_q[0]  <= '0;
      obuf_q[1]  <= '0;
      ob_cnt_q   <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      inflight_q <= inflight_d;
      obuf_q     <= obuf_d;
      ob_cnt_q   <= ob_cnt_d;
    end
  end

  assign bus.enq_ready = enq_ready_w;
  assign bus.deq_valid = deq_valid_w;
  assign bus.deq_bits  = obuf_q[0];
  assign bus.count     = {1'b0, sram_cnt_q} + (ADDR_W+2)'(inflight_q) + (ADDR_W+2)'(ob_cnt_q);

  assign bus.W0_en   = sram_wr;
  assign bus.W0_addr = wr_ptr_q;
  assign bus.W0_data = bus.enq_bits;
  assign bus.W0_mask = '1;

  assign bus.R0_en   = issue;
  assign bus.R0_addr = rd_ptr_q;
endmodule
